// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg : level-width helper and wrapping pointer increment for FIFOs
// Rev 1.0
// ============================================================================
package fifo_pkg;

  // Pointers travel through the helper at a fixed width, then get resized by the caller.
  typedef logic [31:0] fifo_ptr_t;

  function automatic int fifo_level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic fifo_ptr_t fifo_ptr_inc(input fifo_ptr_t ptr, input int depth);
    return (ptr == fifo_ptr_t'(depth - 1)) ? '0 : ptr + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram_2p.sv
`default_nettype none
// ============================================================================
// fifo_ram_2p : WIDTH x DEPTH storage, synchronous write, combinational read
// Rev 1.0
// ============================================================================
module fifo_ram_2p #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
// stream_fifo : valid/ready FWFT FIFO, any DEPTH >= 2, level + almost flags
// Optional peak_level high-water mark: define STREAM_FIFO_PEAK_LEVEL_EN
// Rev 1.0
// ============================================================================
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 8,
  parameter int AFULL_LEVEL  = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1,
  localparam int LW = fifo_level_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    level,
  output logic             almost_full,
  output logic             almost_empty
`ifdef STREAM_FIFO_PEAK_LEVEL_EN
  ,
  output logic [LW-1:0]    peak_level
`endif
);

  localparam int            c_ptr_w     = $clog2(DEPTH);
  localparam logic [LW-1:0] c_full      = LW'(DEPTH);
  localparam logic [LW-1:0] c_afull     = LW'(AFULL_LEVEL);
  localparam logic [LW-1:0] c_aempty    = LW'(AEMPTY_LEVEL);

  logic               w_push;
  logic               w_pop;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] w_wr_ptr_next;
  logic [c_ptr_w-1:0] w_rd_ptr_next;
  logic [LW-1:0]      w_level_next;
  logic [WIDTH-1:0]   w_ram_rdata;
  logic [WIDTH-1:0]   w_head_data;
  logic               w_head_load;
  logic               w_head_bypass;

  always_comb begin
    w_push        = in_valid & in_ready;
    w_pop         = out_valid & out_ready;
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    if (flush) begin
      w_wr_ptr_next = '0;
      w_rd_ptr_next = '0;
    end else begin
      if (w_push) w_wr_ptr_next = c_ptr_w'(fifo_ptr_inc(fifo_ptr_t'(r_wr_ptr), DEPTH));
      if (w_pop)  w_rd_ptr_next = c_ptr_w'(fifo_ptr_inc(fifo_ptr_t'(r_rd_ptr), DEPTH));
    end
    w_level_next  = flush ? '0 : level + LW'(w_push) - LW'(w_pop);
    // Head refills whenever it is consumed or empty; if nothing older remains,
    // the word being written this edge goes straight into the head register.
    w_head_load   = !flush && (w_pop || !out_valid) && (w_level_next != '0);
    w_head_bypass = (level == LW'(w_pop));
    w_head_data   = w_head_bypass ? in_data : w_ram_rdata;
  end

  fifo_ram_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_push & ~flush),
    .waddr (r_wr_ptr),
    .wdata (in_data),
    .raddr (w_rd_ptr_next),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      level        <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_data     <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      r_wr_ptr     <= w_wr_ptr_next;
      r_rd_ptr     <= w_rd_ptr_next;
      level        <= w_level_next;
      in_ready     <= (w_level_next != c_full);
      out_valid    <= (w_level_next != '0);
      almost_full  <= (w_level_next >= c_afull);
      almost_empty <= (w_level_next <= c_aempty);
      if (w_head_load) out_data <= w_head_data;
    end
  end

`ifdef STREAM_FIFO_PEAK_LEVEL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_level <= '0;
    end else if (flush) begin
      peak_level <= '0;
    end else if (w_level_next > peak_level) begin
      peak_level <= w_level_next;
    end
  end
`else
  // No high-water tracking in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo.sv
`default_nettype none
// ============================================================================
// tb_stream_fifo : directed stimulus with queue scoreboard on two FIFO sizes
// Rev 1.0
// ============================================================================
module tb_stream_fifo;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [W-1:0]  a_in_data = '0;
  logic          a_in_ready, a_out_valid, a_af, a_ae;
  logic [W-1:0]  a_out_data;
  logic [3:0]    a_level;

  logic          b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [W-1:0]  b_in_data = '0;
  logic          b_in_ready, b_out_valid, b_af, b_ae;
  logic [W-1:0]  b_out_data;
  logic [2:0]    b_level;

`ifdef STREAM_FIFO_PEAK_LEVEL_EN
  logic [3:0]    a_peak;
  logic [2:0]    b_peak;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  bit a_pushed, b_pushed;

  stream_fifo #(.WIDTH(W), .DEPTH(8), .AFULL_LEVEL(6), .AEMPTY_LEVEL(1)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .level(a_level), .almost_full(a_af), .almost_empty(a_ae)
`ifdef STREAM_FIFO_PEAK_LEVEL_EN
    , .peak_level(a_peak)
`endif
  );

  stream_fifo #(.WIDTH(W), .DEPTH(5)) dut_b (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .level(b_level), .almost_full(b_af), .almost_empty(b_ae)
`ifdef STREAM_FIFO_PEAK_LEVEL_EN
    , .peak_level(b_peak)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Samples handshakes just before the edge, updates the scoreboards, then advances one clock.
  task automatic cycle();
    logic [W-1:0] exp;
    a_pushed = 1'b0;
    b_pushed = 1'b0;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_flush) begin
        qa.delete();
      end else begin
        if (a_out_valid && a_out_ready) begin
          chk("a_pop_with_expected_word", 32'(qa.size() != 0), 32'd1);
          if (qa.size() != 0) begin
            exp = qa.pop_front();
            chk("a_pop_data", a_out_data, exp);
          end
        end
        if (a_in_valid && a_in_ready) begin
          qa.push_back(a_in_data);
          a_pushed = 1'b1;
        end
      end
      if (b_out_valid && b_out_ready) begin
        chk("b_pop_with_expected_word", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) begin
          exp = qb.pop_front();
          chk("b_pop_data", b_out_data, exp);
        end
      end
      if (b_in_valid && b_in_ready) begin
        qb.push_back(b_in_data);
        b_pushed = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] b_words [6];
    int idx;
    int lvl;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_level", a_level, 0);
    chk("rst_almost_full", a_af, 0);
    chk("rst_almost_empty", a_ae, 1);
    chk("rst_b_in_ready", b_in_ready, 1);
    chk("rst_b_level", b_level, 0);
`ifdef STREAM_FIFO_PEAK_LEVEL_EN
    chk("rst_peak", a_peak, 0);
`endif

    // Three pushes with consumer stalled, then three pops
    a_in_valid = 1'b1;
    a_in_data = 32'hA1; cycle();
    chk("t1_latency_valid", a_out_valid, 1);
    chk("t1_latency_data", a_out_data, 32'hA1);
    a_in_data = 32'hA2; cycle();
    a_in_data = 32'hA3; cycle();
    a_in_valid = 1'b0;
    chk("t1_level3", a_level, 3);
    chk("t1_head", a_out_data, 32'hA1);
    chk("t1_valid", a_out_valid, 1);
    a_out_ready = 1'b1;
    cycle();
    chk("t1_level2", a_level, 2);
    cycle();
    cycle();
    a_out_ready = 1'b0;
    chk("t1_empty_valid", a_out_valid, 0);
    chk("t1_empty_level", a_level, 0);

    // DEPTH=5: six back-to-back offers, one held, pointer wrap
    for (int n = 0; n < 6; n++) b_words[n] = 32'hB0 + 32'(n);
    idx = 0;
    b_in_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      b_in_data = b_words[idx];
      cycle();
      if (b_pushed) idx++;
    end
    chk("t2_accepted", 32'(idx), 5);
    chk("t2_full_in_ready", b_in_ready, 0);
    chk("t2_full_level", b_level, 5);
    chk("t2_full_afull", b_af, 1);
    b_in_data = b_words[5];
    cycle();
    chk("t2_held", 32'(b_pushed), 0);
    b_out_ready = 1'b1;
    cycle();
    chk("t2_no_push_on_full_pop", 32'(b_pushed), 0);
    b_out_ready = 1'b0;
    chk("t2_after_pop_level", b_level, 4);
    chk("t2_after_pop_in_ready", b_in_ready, 1);
    cycle();
    chk("t2_sixth_accepted", 32'(b_pushed), 1);
    b_in_valid = 1'b0;
    chk("t2_refull_level", b_level, 5);
    b_out_ready = 1'b1;
    for (int n = 0; n < 8 && b_out_valid; n++) cycle();
    b_out_ready = 1'b0;
    chk("t2_drained_valid", b_out_valid, 0);
    chk("t2_drained_level", b_level, 0);
    chk("t2_scoreboard_empty", 32'(qb.size()), 0);

    // Sustained push+pop at level 2
    a_in_valid = 1'b1;
    for (int n = 0; n < 2; n++) begin
      a_in_data = $urandom;
      cycle();
    end
    a_out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      a_in_data = $urandom;
      cycle();
      chk("t3_level", a_level, 2);
      chk("t3_valid", a_out_valid, 1);
    end
    a_in_valid = 1'b0;
    for (int n = 0; n < 10 && a_out_valid; n++) cycle();
    a_out_ready = 1'b0;
    chk("t3_drained_level", a_level, 0);
    chk("t3_scoreboard_empty", 32'(qa.size()), 0);

    // Almost-full/almost-empty thresholds (6 and 1)
    lvl = 0;
    chk("t4_ae_l0", a_ae, 1);
    a_in_valid = 1'b1;
    for (int n = 0; n < 7; n++) begin
      a_in_data = 32'hC0 + 32'(n);
      cycle();
      lvl++;
      chk("t4_up_level", a_level, 32'(lvl));
      chk("t4_up_af", a_af, 32'(lvl >= 6));
      chk("t4_up_ae", a_ae, 32'(lvl <= 1));
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cycle();
      lvl--;
      chk("t4_down_level", a_level, 32'(lvl));
      chk("t4_down_af", a_af, 32'(lvl >= 6));
      chk("t4_down_ae", a_ae, 32'(lvl <= 1));
    end
    a_out_ready = 1'b0;

    // Flush wins over simultaneous push and pop
    a_flush = 1'b1; cycle(); a_flush = 1'b0;
    chk("t5_preflush_level", a_level, 0);
    a_in_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      a_in_data = 32'hD0 + 32'(n);
      cycle();
    end
    chk("t5_level4", a_level, 4);
`ifdef STREAM_FIFO_PEAK_LEVEL_EN
    chk("t5_peak4", a_peak, 4);
`endif
    a_in_data = 32'hDEAD;
    a_out_ready = 1'b1;
    a_flush = 1'b1;
    cycle();
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    chk("t5_flush_level", a_level, 0);
    chk("t5_flush_valid", a_out_valid, 0);
    chk("t5_flush_in_ready", a_in_ready, 1);
`ifdef STREAM_FIFO_PEAK_LEVEL_EN
    chk("t5_flush_peak", a_peak, 0);
`endif
    a_in_valid = 1'b1; a_in_data = 32'h77;
    cycle();
    a_in_valid = 1'b0;
    chk("t5_after_flush_head", a_out_data, 32'h77);
    a_out_ready = 1'b1;
    cycle();
    a_out_ready = 1'b0;
    chk("t5_after_flush_level", a_level, 0);

    // Asynchronous reset mid-burst at level 3
    a_in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      a_in_data = 32'hE0 + 32'(n);
      cycle();
    end
    chk("t6_level3", a_level, 3);
    a_in_data = 32'hE3;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_in_ready", a_in_ready, 1);
    chk("t6_async_out_valid", a_out_valid, 0);
    chk("t6_async_out_data", a_out_data, 0);
    chk("t6_async_level", a_level, 0);
    chk("t6_async_af", a_af, 0);
    chk("t6_async_ae", a_ae, 1);
`ifdef STREAM_FIFO_PEAK_LEVEL_EN
    chk("t6_async_peak", a_peak, 0);
`endif
    a_in_valid = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    a_in_valid = 1'b1; a_in_data = 32'h55;
    cycle();
    a_in_valid = 1'b0;
    chk("t6_first_word", a_out_data, 32'h55);
    a_out_ready = 1'b1;
    cycle();
    a_out_ready = 1'b0;
    chk("t6_final_level", a_level, 0);
    chk("t6_scoreboard_empty", 32'(qa.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
